db_xfer_seq: RTL and testbench
==============================

// Module: db_xfer_seq
// PURPOSE
//  Sequencer that moves one byte per request over the shared 3-state internal db bus.
//  It drives the oe/we strobes of up to 8 reg_latch instances, or drives an immediate byte
//  onto db itself. It sits directly upstream of the register latches and is their only controller.
//  It guarantees one driver at a time, a write strobe centred inside the drive window,
//  and a bus turnaround cycle.
// PARAMETERS
//  NUM_REGS  8  number of attached latches (1..8); indices >= NUM_REGS are invalid
//  DW        8  data bus width
// PORTS
//  clk       in     1        single clock; all state on rising edge
//  reset     in     1        asynchronous, active-high reset
//  req       in     1        transfer request, sampled in IDLE only
//  src       in     3        source latch index (ignored when imm_sel=1)
//  dst       in     3        destination latch index
//  imm_sel   in     1        1: source is imm_data driven by this block
//  imm_data  in     DW       immediate byte
//  busy      out    1        high from the cycle after acceptance until return to IDLE
//  done      out    1        one-cycle pulse, in HOLD
//  err       out    1        one-cycle pulse with done when src/dst index invalid
//  rd_data   out    DW       byte seen on db at end of WRITE; held until next capture
//  oe        out    NUM_REGS one-hot (or zero) output enables to latches
//  we        out    NUM_REGS one-hot (or zero) write enables to latches
//  db        inout  DW       shared bus; driven only when imm_sel transfer active, else Z
// BEHAVIOUR
//  Reset (async): state=IDLE; oe=0, we=0, busy=0, done=0, err=0, rd_data=0, db=Z.
//   This takes effect immediately, including mid-transfer; no strobe may glitch high after reset rises.
//  FSM: IDLE -> DRIVE -> WRITE -> HOLD -> TURN -> IDLE. Each non-IDLE state lasts exactly 1 cycle.
//  IDLE: On posedge with req=1, register src, dst, imm_sel, imm_data, then go to DRIVE.
//   Outputs are quiet (all strobes 0, db Z).
//  DRIVE: If imm_sel=0, oe[src]=1; if imm_sel=1, db=imm_data. we=0.
//  WRITE: The source drive continues. we[dst]=1. At the end of the cycle, rd_data<=db.
//  HOLD: The source drive continues (data hold after we falls). we=0. done=1. err=1 if invalid.
//  TURN: oe=0, db=Z, we=0, busy=1. No new request is accepted. This is the turnaround cycle.
//  Latency: request accepted at edge N; done is high in cycle N+3; busy=0 and next accept at edge N+4.
//   Back-to-back requests held high give 1 transfer per 4 cycles.
//  A req arriving while busy is ignored and not queued. req needs no deassert between transfers.
//  src==dst with imm_sel=0 is a read probe: oe[src] asserts, no we asserts, rd_data captures, err=0.
//  src >= NUM_REGS with imm_sel=0: no oe asserts and db floats.
//   The write to dst is still suppressed, rd_data is captured as-is, and err=1.
//  dst >= NUM_REGS: no we asserts; err=1; the source drive still runs normally.
//  Invariant: at most one of {oe bits, own db drive} is active in any cycle. we is never high in DRIVE or TURN.
//  All strobes are registered outputs (glitch-free); db output enable is registered.
// TESTING
//  1 Reset: assert reset mid-WRITE -> same cycle oe=0, we=0, db=Z, busy=0, rd_data=0; next req starts cleanly.
//  2 Immediate: req, imm_sel=1, imm_data=8'h55, dst=2 -> db=8'h55 in DRIVE..HOLD.
//    we[2] high only in WRITE; latch 2 reads back 8'h55; done at N+3.
//  3 Reg copy: preload latch1=8'hAA; req src=1, dst=4 -> oe=8'b0000_0010 for 3 cycles.
//    we=8'b0001_0000 in WRITE; rd_data=8'hAA; latch4 reads 8'hAA.
//  4 Read probe: src=dst=3 holding 8'h3C -> we stays 0; rd_data=8'h3C; err=0.
//  5 Back-to-back: req held high for 3 transfers -> done pulses 4 cycles apart.
//    db is Z in every TURN; req pulsed while busy is dropped.
//  6 Invalid: NUM_REGS=4, dst=6, imm_data=8'h11 -> no we bit set; err=1 with done. Latch contents unchanged.

Source files
------------

// File: rtl/db_xfer_seq.sv
// db_xfer_seq: moves one byte per request over the shared db bus by strobing latch oe/we
// or driving an immediate byte, with a one-cycle turnaround before the next transfer.
module db_xfer_seq #(
  parameter int NUM_REGS = 8,
  parameter int DW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                req,
  input  logic [2:0]          src,
  input  logic [2:0]          dst,
  input  logic                imm_sel,
  input  logic [DW-1:0]       imm_data,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [DW-1:0]       rd_data,
  output logic [NUM_REGS-1:0] oe,
  output logic [NUM_REGS-1:0] we,
  inout  wire  [DW-1:0]       db
);
  typedef enum logic [2:0] {IDLE, DRIVE, WRITE, HOLD, TURN} state_t;
  localparam logic [NUM_REGS-1:0] ONE = 1;
  state_t state;
  logic [2:0] src_q, dst_q;
  logic imm_q, db_en, take, in_src_ok, src_ok, dst_ok, wr_ok, bad_idx;
  logic [DW-1:0] db_out;
  always_comb begin
    in_src_ok = {29'd0, src} < 32'(NUM_REGS);
    src_ok = {29'd0, src_q} < 32'(NUM_REGS);
    dst_ok = {29'd0, dst_q} < 32'(NUM_REGS);
    wr_ok = dst_ok && (imm_q || (src_ok && src_q != dst_q));
    bad_idx = !dst_ok || (!imm_q && !src_ok);
    take = req && (state == IDLE || state == TURN);
  end
  // TURN keeps the bus released for its whole cycle; a request seen on its closing edge starts the next DRIVE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
      rd_data <= '0;
      oe <= '0;
      we <= '0;
      db_en <= 1'b0;
      db_out <= '0;
      src_q <= '0;
      dst_q <= '0;
      imm_q <= 1'b0;
    end else begin
      done <= 1'b0;
      err <= 1'b0;
      we <= '0;
      if (take) begin
        state <= DRIVE;
        busy <= 1'b1;
        src_q <= src;
        dst_q <= dst;
        imm_q <= imm_sel;
        db_out <= imm_data;
        db_en <= imm_sel;
        oe <= (!imm_sel && in_src_ok) ? ONE << src : '0;
      end else case (state)
        DRIVE: begin
          state <= WRITE;
          we <= wr_ok ? ONE << dst_q : '0;
        end
        WRITE: begin
          state <= HOLD;
          done <= 1'b1;
          err <= bad_idx;
          rd_data <= db;
        end
        HOLD: begin
          state <= TURN;
          oe <= '0;
          db_en <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end
  assign db = db_en ? db_out : 'z;
endmodule

// File: tb/tb_db_xfer_seq.sv
// tb_db_xfer_seq: directed and random transfers against a latch-array model of the db bus.
module tb_db_xfer_seq;
  localparam int NR = 6;
  logic clk = 1'b0, reset = 1'b1, req = 1'b0, imm_sel = 1'b0;
  logic [2:0] src = '0, dst = '0;
  logic [7:0] imm_data = '0;
  logic busy, done, err;
  logic [7:0] rd_data;
  logic [NR-1:0] oe, we;
  wire [7:0] db;
  logic [7:0] lat [NR] = '{default: 8'h00};
  logic [7:0] m_lat [8] = '{default: 8'h00};
  int total = 0, bad = 0;

  db_xfer_seq #(.NUM_REGS(NR), .DW(8)) dut (
    .clk(clk), .reset(reset), .req(req), .src(src), .dst(dst), .imm_sel(imm_sel),
    .imm_data(imm_data), .busy(busy), .done(done), .err(err), .rd_data(rd_data),
    .oe(oe), .we(we), .db(db)
  );

  always #5 clk = ~clk;

  for (genvar g = 0; g < NR; g++) begin : g_lat
    assign db = oe[g] ? lat[g] : 'z;
  end

  always @(posedge clk) for (int j = 0; j < NR; j++) if (we[j]) lat[j] <= db;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic xfer(input logic [2:0] s, input logic [2:0] d, input logic i,
                      input logic [7:0] v, input bit hold, input bit poke);
    logic sv, wr, e;
    logic [7:0] val, eoe, ewe;
    src = s; dst = d; imm_sel = i; imm_data = v; req = 1'b1;
    sv = i || int'(s) < NR;
    val = i ? v : (int'(s) < NR ? m_lat[s] : 8'h00);
    eoe = (!i && int'(s) < NR) ? 8'd1 << s : 8'd0;
    wr = int'(d) < NR && (i || (int'(s) < NR && s != d));
    ewe = wr ? 8'd1 << d : 8'd0;
    e = int'(d) >= NR || (!i && int'(s) >= NR);
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 0) begin
        req = hold; imm_data = ~v; src = 3'($urandom); dst = 3'($urandom);
      end
      if (k == 1 && poke) req = 1'b1;
      if (k == 2 && poke) req = hold;
      chk("busy", 32'(busy), 32'd1);
      chk("oe", 32'(oe), k < 3 ? 32'(eoe) : 32'd0);
      chk("we", 32'(we), k == 1 ? 32'(ewe) : 32'd0);
      chk("done", 32'(done), 32'(k == 2));
      chk("err", 32'(err), 32'(k == 2 && e));
      chk("db_en", 32'(dut.db_en), 32'(k < 3 && i));
      if (k < 3 && sv) chk("db", 32'(db), 32'(val));
      if (k >= 2 && sv) chk("rd_data", 32'(rd_data), 32'(val));
    end
    if (wr) m_lat[d] = val;
    if (int'(d) < NR) chk("latch", 32'(lat[d]), 32'(m_lat[d]));
  endtask

  task automatic idle_chk();
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_oe", 32'(oe), 32'd0);
    chk("idle_db_en", 32'(dut.db_en), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_oe", 32'(oe), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_rd", 32'(rd_data), 32'd0);
    chk("rst_db_en", 32'(dut.db_en), 32'd0);
    reset = 1'b0;
    // reset raised in the middle of WRITE
    src = 3'd1; dst = 3'd0; imm_sel = 1'b1; imm_data = 8'h5A; req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_oe", 32'(oe), 32'd0);
    chk("mid_we", 32'(we), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_db_en", 32'(dut.db_en), 32'd0);
    chk("mid_rd", 32'(rd_data), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_latch0", 32'(lat[0]), 32'd0);
    xfer(3'd0, 3'd2, 1'b1, 8'h55, 1'b0, 1'b0);
    idle_chk();
    xfer(3'd0, 3'd1, 1'b1, 8'hAA, 1'b0, 1'b0);
    xfer(3'd1, 3'd4, 1'b0, 8'h00, 1'b0, 1'b0);
    xfer(3'd0, 3'd3, 1'b1, 8'h3C, 1'b0, 1'b0);
    xfer(3'd3, 3'd3, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_chk();
    xfer(3'd0, 3'd0, 1'b1, 8'h12, 1'b1, 1'b0);
    xfer(3'd2, 3'd5, 1'b0, 8'h00, 1'b1, 1'b0);
    xfer(3'd5, 3'd1, 1'b0, 8'h00, 1'b0, 1'b1);
    idle_chk();
    xfer(3'd0, 3'd6, 1'b1, 8'h11, 1'b0, 1'b0);
    xfer(3'd7, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    xfer(3'd4, 3'd7, 1'b0, 8'h00, 1'b0, 1'b0);
    idle_chk();
    for (int n = 0; n < 30; n++)
      xfer(3'($urandom), 3'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    req = 1'b0;
    idle_chk();
    for (int j = 0; j < NR; j++) chk("final_latch", 32'(lat[j]), 32'(m_lat[j]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
